// File: rtl/sm_host_drv.sv
// sm_host_drv: host-side driver for the serial string-match interface.
// Holds one string and one pattern in local buffers written by a controller
// while idle. A job serialises the string (optional) and the pattern onto
// chardata/isstring/ispattern, then waits for the matcher's valid strobe and
// reports the captured result with a one-cycle res_valid pulse.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   str_we/str_waddr    string buffer write (accepted only when idle)
//   pat_we/pat_waddr    pattern buffer write (accepted only when idle)
//   wdata               buffer write data
//   str_len/pat_len     job lengths, sampled at start (0 -> 1, saturating)
//   start, send_str     job request; send_str forces string transmission
//   busy                high while a job is in progress
//   chardata/isstring/ispattern  serial interface to the matcher
//   match/match_index/valid      matcher result
//   res_valid/res_match/res_index/res_timeout  captured job result
//
// Optional build macro SM_HOST_DRV_STATS_EN adds job_cnt and match_cnt,
// saturating counters of completed jobs and of completed matching jobs.
module sm_host_drv #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              str_we,
  input  logic [4:0]        str_waddr,
  input  logic              pat_we,
  input  logic [2:0]        pat_waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [5:0]        str_len,
  input  logic [3:0]        pat_len,
  input  logic              start,
  input  logic              send_str,
  output logic              busy,
  output logic [DATA_W-1:0] chardata,
  output logic              isstring,
  output logic              ispattern,
  input  logic              match,
  input  logic [4:0]        match_index,
  input  logic              valid,
  output logic              res_valid,
  output logic              res_match,
  output logic [4:0]        res_index,
  output logic              res_timeout
`ifdef SM_HOST_DRV_STATS_EN
  ,
  output logic [7:0]        job_cnt,
  output logic [7:0]        match_cnt
`endif
);

  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  str_mem [STR_MAX];
  logic [DATA_W-1:0]  pat_mem [PAT_MAX];
  logic [5:0]         slen, slen_n, slen_eff;
  logic [3:0]         plen, plen_n, plen_eff;
  logic [5:0]         idx, idx_n;
  logic [7:0]         tcnt, tcnt_n;
  logic               str_sent, str_sent_n;
  logic               busy_n, isstring_n, ispattern_n, res_valid_n;
  logic               res_match_n, res_timeout_n;
  logic [4:0]         res_index_n;
  logic [DATA_W-1:0]  chardata_n;

  // Buffer storage; writes are dropped while a job is running.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (str_we) str_mem[SAW'(str_waddr)] <= wdata;
      if (pat_we) pat_mem[PAW'(pat_waddr)] <= wdata;
    end
  end

  // Effective job lengths: zero means one, overlong saturates to the buffer depth.
  always_comb begin
    slen_eff = str_len;
    plen_eff = pat_len;
    if (str_len == 6'd0)              slen_eff = 6'd1;
    else if (str_len > 6'(STR_MAX))   slen_eff = 6'(STR_MAX);
    if (pat_len == 4'd0)              plen_eff = 4'd1;
    else if (pat_len > 4'(PAT_MAX))   plen_eff = 4'(PAT_MAX);
  end

  // Next state plus next values of the registered outputs. idx holds the
  // index of the next character to drive, since the current one is already
  // on the output registers.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    slen_n        = slen;
    plen_n        = plen;
    tcnt_n        = tcnt;
    str_sent_n    = str_sent;
    chardata_n    = '0;
    isstring_n    = 1'b0;
    ispattern_n   = 1'b0;
    res_valid_n   = 1'b0;
    res_match_n   = res_match;
    res_index_n   = res_index;
    res_timeout_n = res_timeout;

    case (state)
      IDLE: begin
        if (start) begin
          slen_n = slen_eff;
          plen_n = plen_eff;
          idx_n  = 6'd1;
          if (send_str || !str_sent) begin
            state_n    = SEND_STR;
            chardata_n = str_mem[SAW'(0)];
            isstring_n = 1'b1;
          end else begin
            state_n     = SEND_PAT;
            chardata_n  = pat_mem[PAW'(0)];
            ispattern_n = 1'b1;
          end
        end
      end
      SEND_STR: begin
        str_sent_n = 1'b1;
        if (idx == slen) begin
          state_n     = SEND_PAT;
          chardata_n  = pat_mem[PAW'(0)];
          ispattern_n = 1'b1;
          idx_n       = 6'd1;
        end else begin
          chardata_n = str_mem[SAW'(idx)];
          isstring_n = 1'b1;
          idx_n      = idx + 6'd1;
        end
      end
      SEND_PAT: begin
        if (idx == {2'b00, plen}) begin
          // tcnt counts clock edges since entering WAIT, the entry edge included
          state_n = WAIT;
          idx_n   = 6'd0;
          tcnt_n  = 8'd1;
        end else begin
          chardata_n  = pat_mem[PAW'(idx)];
          ispattern_n = 1'b1;
          idx_n       = idx + 6'd1;
        end
      end
      WAIT: begin
        tcnt_n = tcnt + 8'd1;
        if (valid) begin
          state_n       = DONE;
          res_match_n   = match;
          res_index_n   = match_index;
          res_timeout_n = 1'b0;
        end else if (tcnt_n >= 8'(TIMEOUT)) begin
          state_n       = DONE;
          res_match_n   = 1'b0;
          res_index_n   = 5'd0;
          res_timeout_n = 1'b1;
        end
      end
      DONE: begin
        res_valid_n = 1'b1;
        tcnt_n      = 8'd0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      slen        <= '0;
      plen        <= '0;
      tcnt        <= '0;
      str_sent    <= 1'b0;
      busy        <= 1'b0;
      chardata    <= '0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= '0;
      res_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      slen        <= slen_n;
      plen        <= plen_n;
      tcnt        <= tcnt_n;
      str_sent    <= str_sent_n;
      busy        <= busy_n;
      chardata    <= chardata_n;
      isstring    <= isstring_n;
      ispattern   <= ispattern_n;
      res_valid   <= res_valid_n;
      res_match   <= res_match_n;
      res_index   <= res_index_n;
      res_timeout <= res_timeout_n;
    end
  end

`ifdef SM_HOST_DRV_STATS_EN
  // Saturating job statistics, advanced on each result pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_cnt   <= 8'd0;
      match_cnt <= 8'd0;
    end else if (res_valid) begin
      if (job_cnt != 8'hFF)                 job_cnt   <= job_cnt + 8'd1;
      if (res_match && match_cnt != 8'hFF)  match_cnt <= match_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_host_drv.sv
// Self-checking bench for sm_host_drv: directed scenarios plus randomized
// jobs compared against a behavioural model of buffers, lengths and results.
module tb_sm_host_drv;

  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 255;
  localparam int MODE_RESP = 0;
  localparam int MODE_TMO  = 1;
  localparam int MODE_RST  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              str_we;
  logic [4:0]        str_waddr;
  logic              pat_we;
  logic [2:0]        pat_waddr;
  logic [DATA_W-1:0] wdata;
  logic [5:0]        str_len;
  logic [3:0]        pat_len;
  logic              start;
  logic              send_str;
  logic              busy;
  logic [DATA_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              match;
  logic [4:0]        match_index;
  logic              valid;
  logic              res_valid;
  logic              res_match;
  logic [4:0]        res_index;
  logic              res_timeout;
`ifdef SM_HOST_DRV_STATS_EN
  logic [7:0]        job_cnt;
  logic [7:0]        match_cnt;
  int                m_jobs = 0;
  int                m_matches = 0;
`endif

  sm_host_drv #(
    .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .str_we(str_we), .str_waddr(str_waddr),
    .pat_we(pat_we), .pat_waddr(pat_waddr),
    .wdata(wdata), .str_len(str_len), .pat_len(pat_len),
    .start(start), .send_str(send_str), .busy(busy),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .match(match), .match_index(match_index), .valid(valid),
    .res_valid(res_valid), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout)
`ifdef SM_HOST_DRV_STATS_EN
    , .job_cnt(job_cnt), .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_str [STR_MAX];
  logic [DATA_W-1:0] m_pat [PAT_MAX];
  bit                m_str_sent = 1'b0;
  bit                m_match    = 1'b0;
  logic [4:0]        m_index    = 5'd0;
  bit                m_tmo      = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout};
  endfunction

  // Buffer writes: called at a negedge in IDLE, return at the next negedge.
  task automatic wr_str(input int a, input logic [7:0] d);
    str_we = 1'b1; str_waddr = 5'(a); wdata = d;
    @(negedge clk);
    str_we = 1'b0;
    m_str[a] = d;
  endtask

  task automatic wr_pat(input int a, input logic [7:0] d);
    pat_we = 1'b1; pat_waddr = 3'(a); wdata = d;
    @(negedge clk);
    pat_we = 1'b0;
    m_pat[a] = d;
  endtask

  task automatic load_all();
    for (int i = 0; i < int'(STR_MAX); i++) wr_str(i, 8'($urandom));
    for (int i = 0; i < int'(PAT_MAX); i++) wr_pat(i, 8'($urandom));
  endtask

  task automatic note_result(input bit mt, input logic [4:0] mi, input bit to);
    m_match = mt; m_index = mi; m_tmo = to;
`ifdef SM_HOST_DRV_STATS_EN
    m_jobs++;
    if (mt) m_matches++;
`endif
  endtask

  // One job: expected character stream from the model, then result handling.
  task automatic run_job(input int sl, input int pl, input bit ss, input int mode,
                         input int dly, input bit mt, input logic [4:0] mi,
                         input bit start_in_pat, input bit we_busy);
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int sle, ple, n;
    bit saw;
    sle = (sl == 0) ? 1 : (sl > int'(STR_MAX)) ? int'(STR_MAX) : sl;
    ple = (pl == 0) ? 1 : (pl > int'(PAT_MAX)) ? int'(PAT_MAX) : pl;
    if (ss || !m_str_sent) begin
      for (int i = 0; i < sle; i++) exp_q.push_back({2'b10, m_str[i]});
      m_str_sent = 1'b1;
    end
    for (int i = 0; i < ple; i++) exp_q.push_back({2'b01, m_pat[i]});

    str_len = 6'(sl); pat_len = 4'(pl); send_str = ss; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_rise", busy, 1);
    n = 0;
    while ((isstring || ispattern) && n < 100) begin
      obs_q.push_back({isstring, ispattern, chardata});
      start = start_in_pat && ispattern;
      if (we_busy) begin
        str_we = 1'b1; str_waddr = 5'($urandom); wdata = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; str_we = 1'b0;
    check_eq("seq_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("seq[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));
    check_eq("wait_bus_idle", {isstring, ispattern, chardata}, 0);
    check_eq("wait_busy", busy, 1);

    case (mode)
      MODE_RESP: begin
        repeat (dly) @(negedge clk);
        valid = 1'b1; match = mt; match_index = mi;
        @(negedge clk);
        valid = 1'b0; match = 1'($urandom); match_index = 5'($urandom);
        check_eq("rv_early", res_valid, 0);
        @(negedge clk);
        check_eq("rv_pulse", res_valid, 1);
        check_eq("res_match", res_match, 32'(mt));
        check_eq("res_index", res_index, 32'(mi));
        check_eq("res_timeout", res_timeout, 0);
        note_result(mt, mi, 1'b0);
        @(negedge clk);
        check_eq("rv_one_cycle", res_valid, 0);
        check_eq("res_hold", {res_match, res_index}, {mt, mi});
        check_eq("idle_after", busy, 0);
      end
      MODE_TMO: begin
        n = 0;
        while (!res_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        check_eq("tmo_cycles", n, TIMEOUT);
        check_eq("tmo_flag", res_timeout, 1);
        check_eq("tmo_result", {res_match, res_index}, 0);
        note_result(1'b0, 5'd0, 1'b1);
        @(negedge clk);
        check_eq("tmo_rv_one_cycle", res_valid, 0);
        check_eq("tmo_idle", busy, 0);
      end
      default: begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_outs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        m_str_sent = 1'b0; m_match = 1'b0; m_index = 5'd0; m_tmo = 1'b0;
`ifdef SM_HOST_DRV_STATS_EN
        m_jobs = 0; m_matches = 0;
`endif
        saw = 1'b0;
        repeat (4) begin
          @(negedge clk);
          saw |= res_valid;
        end
        check_eq("rst_no_rv", saw, 0);
        check_eq("rst_idle_outs", all_outs(), 0);
        load_all();
      end
    endcase
  endtask

  task automatic spurious_valid();
    bit saw;
    valid = 1'b1; match = 1'b1; match_index = 5'h1f;
    @(negedge clk);
    valid = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      saw |= res_valid;
      @(negedge clk);
    end
    check_eq("spur_no_rv", saw, 0);
    check_eq("spur_res_held", {res_match, res_index, res_timeout}, {m_match, m_index, m_tmo});
    check_eq("spur_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1; str_we = 1'b0; str_waddr = '0; pat_we = 1'b0; pat_waddr = '0;
    wdata = '0; str_len = '0; pat_len = '0; start = 1'b0; send_str = 1'b0;
    match = 1'b0; match_index = '0; valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", all_outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    load_all();
    wr_str(0, 8'h61); wr_str(1, 8'h62); wr_str(2, 8'h63);
    wr_pat(0, 8'h62);

    // Nothing sent since reset: string goes out even with send_str=0
    run_job(3, 1, 1'b0, MODE_RESP, 1, 1'b1, 5'd1, 1'b0, 1'b0);
    // Basic "abc" / "b" job
    run_job(3, 1, 1'b1, MODE_RESP, 2, 1'b1, 5'd1, 1'b0, 1'b0);
    // Pattern reuse without string
    wr_pat(0, 8'h63);
    run_job(3, 1, 1'b0, MODE_RESP, 0, 1'b1, 5'd2, 1'b0, 1'b0);
    // No responder
    run_job(3, 1, 1'b0, MODE_TMO, 0, 1'b0, 5'd0, 1'b0, 1'b0);
    // Length limits
    run_job(5, 12, 1'b0, MODE_RESP, 3, 1'b0, 5'd0, 1'b0, 1'b0);
    run_job(0, 2, 1'b1, MODE_RESP, 1, 1'b1, 5'd3, 1'b0, 1'b0);
    run_job(63, 0, 1'b1, MODE_RESP, 0, 1'b0, 5'd4, 1'b0, 1'b0);
    // start during pattern and buffer writes while busy, then resend string
    run_job(4, 6, 1'b1, MODE_RESP, 2, 1'b0, 5'd7, 1'b1, 1'b1);
    run_job(4, 2, 1'b1, MODE_RESP, 1, 1'b1, 5'd9, 1'b0, 1'b0);
    spurious_valid();
    // Reset while waiting, then string forced again
    run_job(6, 3, 1'b1, MODE_RST, 0, 1'b0, 5'd0, 1'b0, 1'b0);
    run_job(2, 2, 1'b0, MODE_RESP, 1, 1'b1, 5'd5, 1'b0, 1'b0);

    for (int j = 0; j < 30; j++) begin
      repeat ($urandom_range(0, 3)) wr_str(int'($urandom_range(0, STR_MAX - 1)), 8'($urandom));
      repeat ($urandom_range(0, 2)) wr_pat(int'($urandom_range(0, PAT_MAX - 1)), 8'($urandom));
      run_job(int'($urandom_range(0, 40)), int'($urandom_range(0, 12)), 1'($urandom),
              MODE_RESP, int'($urandom_range(0, 6)), 1'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom));
    end
    spurious_valid();

`ifdef SM_HOST_DRV_STATS_EN
    check_eq("job_cnt", job_cnt, 32'(m_jobs));
    check_eq("match_cnt", match_cnt, 32'(m_matches));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
